// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: FSM states, decoder
// function codes and the default operand width.
package mips_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1a;

endpackage

// File: rtl/muldiv_unit_if.sv
// Decoder/datapath-facing bundle of the multiply/divide unit.
interface muldiv_unit_if
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
);

    logic             start_mult;
    logic             start_div;
    logic             rd_hi;
    logic             rd_lo;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             stall;
    logic             div_by_zero;

    modport master (
        output start_mult, start_div, rd_hi, rd_lo, srca, srcb,
        input  result, busy, stall, div_by_zero
    );

    modport slave (
        input  start_mult, start_div, rd_hi, rd_lo, srca, srcb,
        output result, busy, stall, div_by_zero
    );

endinterface

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide,
// one bit per step, leaving the raw {hi,lo} in a 2*WIDTH accumulator.
module muldiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             load_div,
    input  logic             step_mul,
    input  logic             step_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic             last,
    output logic [WIDTH-1:0] raw_hi,
    output logic [WIDTH-1:0] raw_lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;

    always_comb begin
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, opnd_q};
        // remainder < divisor < 2^WIDTH, so a set top bit always means "fits"
        ge      = shifted[WIDTH] | ~diff[WIDTH];

        if (load) begin
            cnt_d  = '0;
            opnd_d = load_div ? mag_b : mag_a;
            acc_d  = {{WIDTH{1'b0}}, (load_div ? mag_a : mag_b)};
        end else if (step_mul) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
        end else if (step_div) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last   = (cnt_q == CNT_W'(WIDTH-1));
    assign raw_hi = acc_q[2*WIDTH-1:WIDTH];
    assign raw_lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide with architectural HI/LO, pipeline
// stall generation and mfhi/mflo read-back.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   orig_a_q, orig_a_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               dbz_q, dbz_d;

    logic               busy;
    logic               accept;
    logic               take_div;
    logic               core_last;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   raw_hi, raw_lo;
    logic [2*WIDTH-1:0] prod_mag, prod;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign busy     = (state_q != S_IDLE);
    assign accept   = !busy && (bus.start_mult || bus.start_div);
    assign take_div = bus.start_div && !bus.start_mult;
    assign mag_a    = magnitude(bus.srca);
    assign mag_b    = magnitude(bus.srcb);

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_div (take_div),
        .step_mul (state_q == S_MUL),
        .step_div (state_q == S_DIV),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .last     (core_last),
        .raw_hi   (raw_hi),
        .raw_lo   (raw_lo)
    );

    assign prod_mag = {raw_hi, raw_lo};
    assign prod     = neg_res_q ? (~prod_mag + 1'b1) : prod_mag;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        orig_a_d   = orig_a_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        is_div_d   = is_div_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = take_div ? S_DIV : S_MUL;
                    neg_res_d  = bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1];
                    neg_rem_d  = bus.srca[WIDTH-1];
                    is_div_d   = take_div;
                    dbz_pend_d = take_div && (bus.srcb == '0);
                    orig_a_d   = bus.srca;
                    dbz_d      = 1'b0;
                end
            end
            S_MUL: begin
                if (core_last) state_d = S_FIX;
            end
            S_DIV: begin
                if (core_last) begin
                    state_d = S_FIX;
                    dbz_d   = dbz_pend_q;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dbz_pend_q) begin
                    // the core ran anyway; its result is replaced, not used
                    lo_d = '1;
                    hi_d = orig_a_q;
                end else begin
                    lo_d = neg_res_q ? (~raw_lo + 1'b1) : raw_lo;
                    hi_d = neg_rem_q ? (~raw_hi + 1'b1) : raw_hi;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            orig_a_q   <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            orig_a_q   <= orig_a_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            is_div_q   <= is_div_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.busy        = busy;
    assign bus.stall       = busy && (bus.start_mult || bus.start_div || bus.rd_hi || bus.rd_lo);
    assign bus.div_by_zero = dbz_q;
    assign bus.result      = bus.rd_hi ? hi_q : (bus.rd_lo ? lo_q : '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded directed test of muldiv_unit: reads queue expectations that a
// negedge monitor checks whenever an unstalled mfhi/mflo is presented.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = W + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: any unstalled read is a DUT response to be matched.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (bus.rd_hi || bus.rd_lo) && !bus.stall) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got 0x%08h, expected no read", bus.result);
            end else begin
                e = sb_q.pop_front();
                check(e.name, bus.result, e.res);
                check({e.name, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
            end
        end
    end

    task automatic expect_read(input string name, input logic [31:0] res, input logic dbz);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.dbz  = dbz;
        sb_q.push_back(e);
    endtask

    task automatic read(input string name, input bit hi, input logic [31:0] res, input logic dbz);
        @(posedge clk); #1;
        bus.rd_hi = hi;
        bus.rd_lo = !hi;
        expect_read(name, res, dbz);
        @(posedge clk); #1;
        bus.rd_hi = 1'b0;
        bus.rd_lo = 1'b0;
    endtask

    task automatic issue(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start_mult = mul;
        bus.start_div  = dv;
        bus.srca       = a;
        bus.srcb       = b;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
    endtask

    // Counts busy cycles (and stalled ones) up to the first idle negedge.
    task automatic wait_idle(output int n, output int stalls);
        n = 0;
        stalls = 0;
        while (n <= 200) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (bus.stall) stalls++;
        end
    endtask

    task automatic run(input string name, input bit dv, input logic [31:0] a, input logic [31:0] b);
        int n, s;
        issue(!dv, dv, a, b);
        wait_idle(n, s);
        check({name, "_busy_cycles"}, 32'(n), 32'(LAT));
    endtask

    initial begin : stimulus
        int n, s;
        reset          = 1'b1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.rd_hi      = 1'b0;
        bus.rd_lo      = 1'b0;
        bus.srca       = '0;
        bus.srcb       = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_result", bus.result, 32'd0);
        read("rst_hi", 1'b1, 32'd0, 1'b0);
        read("rst_lo", 1'b0, 32'd0, 1'b0);

        run("t1_mul_7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        read("t1_lo", 1'b0, 32'hFFFF_FFEB, 1'b0);
        read("t1_hi", 1'b1, 32'hFFFF_FFFF, 1'b0);

        run("t2_div_100_7", 1'b1, 32'd100, 32'd7);
        read("t2a_lo", 1'b0, 32'd14, 1'b0);
        read("t2a_hi", 1'b1, 32'd2, 1'b0);
        run("t2_div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        read("t2b_lo", 1'b0, 32'hFFFF_FFFD, 1'b0);
        read("t2b_hi", 1'b1, 32'hFFFF_FFFF, 1'b0);

        run("t3_div_5_0", 1'b1, 32'd5, 32'd0);
        read("t3a_lo", 1'b0, 32'hFFFF_FFFF, 1'b1);
        read("t3a_hi", 1'b1, 32'd5, 1'b1);
        run("t3_div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        read("t3b_hi", 1'b1, 32'hFFFF_FFFB, 1'b1);
        issue(1'b1, 1'b0, 32'd2, 32'd3);
        check("t3_dbz_cleared_on_accept", 32'(bus.div_by_zero), 32'd0);
        wait_idle(n, s);
        check("t3_mul_busy_cycles", 32'(n), 32'(LAT));
        read("t3c_lo", 1'b0, 32'd6, 1'b0);
        read("t3c_hi", 1'b1, 32'd0, 1'b0);

        // mflo held through the whole operation, then mfhi
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        bus.rd_lo = 1'b1;
        expect_read("t4_lo_after_stall", 32'd0, 1'b0);
        wait_idle(n, s);
        check("t4_busy_cycles", 32'(n), 32'(LAT));
        check("t4_stall_cycles", 32'(s), 32'(LAT));
        @(posedge clk); #1;
        bus.rd_lo = 1'b0;
        bus.rd_hi = 1'b1;
        expect_read("t4_hi", 32'd1, 1'b0);
        @(posedge clk); #1;
        bus.rd_hi = 1'b0;

        // both starts plus mfhi in one idle cycle: mult wins, read sees old HI
        @(posedge clk); #1;
        bus.start_mult = 1'b1;
        bus.start_div  = 1'b1;
        bus.srca       = 32'd3;
        bus.srcb       = 32'd4;
        bus.rd_hi      = 1'b1;
        expect_read("t5_old_hi", 32'd1, 1'b0);
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.rd_hi      = 1'b0;
        wait_idle(n, s);
        check("t5_prio_busy_cycles", 32'(n), 32'(LAT));
        read("t5_prio_lo", 1'b0, 32'd12, 1'b0);
        read("t5_prio_hi", 1'b1, 32'd0, 1'b0);

        run("t5_div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        read("t5_ovf_lo", 1'b0, 32'h8000_0000, 1'b0);
        read("t5_ovf_hi", 1'b1, 32'd0, 1'b0);

        // div presented while busy is held off, then taken; mflo sees old LO
        issue(1'b1, 1'b0, 32'd5, 32'd6);
        bus.start_div = 1'b1;
        bus.srca      = 32'd20;
        bus.srcb      = 32'd4;
        bus.rd_lo     = 1'b1;
        expect_read("t7_old_lo", 32'd30, 1'b0);
        wait_idle(n, s);
        check("t7_mul_busy_cycles", 32'(n), 32'(LAT));
        check("t7_stall_cycles", 32'(s), 32'(LAT));
        @(posedge clk); #1;
        bus.start_div = 1'b0;
        bus.rd_lo     = 1'b0;
        wait_idle(n, s);
        check("t7_div_busy_cycles", 32'(n), 32'(LAT));
        read("t7_lo", 1'b0, 32'd5, 1'b0);
        read("t7_hi", 1'b1, 32'd0, 1'b0);

        // reset during a multiply
        issue(1'b1, 1'b0, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_busy_after_reset", 32'(bus.busy), 32'd0);
        read("t6_hi", 1'b1, 32'd0, 1'b0);
        read("t6_lo", 1'b0, 32'd0, 1'b0);
        run("t6_div_9_3", 1'b1, 32'd9, 32'd3);
        read("t6_div_lo", 1'b0, 32'd3, 1'b0);
        read("t6_div_hi", 1'b1, 32'd0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle signed multiply/divide engine with architectural HI/LO registers.
- Consumes the mult, div, mflo and mfhi controls from the main decoder, and the ALU source operands from the datapath.
- Drives a stall to the hazard unit while an operation is in flight, and returns HI or LO on the result bus for mfhi/mflo writeback.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start_mult  in  1  decoder mult qualified by a valid instruction in EX.
- start_div  in  1  decoder div qualified by a valid instruction in EX.
- rd_hi  in  1  decoder mfhi, EX stage.
- rd_lo  in  1  decoder mflo, EX stage.
- srca  in  WIDTH  rs operand (multiplicand or dividend).
- srcb  in  WIDTH  rt operand (multiplier or divisor).
- result  out  WIDTH  HI when rd_hi, LO when rd_lo, else 0.
- busy  out  1  operation in flight (state != IDLE).
- stall  out  1  busy & (start_mult | start_div | rd_hi | rd_lo).
- div_by_zero  out  1  sticky flag from last div; cleared by next accepted start.

Behaviour:
- Reset: state=IDLE; HI=LO=0; busy=0; stall=0; div_by_zero=0; result=0.
- States:
  - IDLE: accept start when not busy. start_mult has priority if both starts are high. In the accept cycle, latch |srca|, |srcb|, sign_q = srca[W-1]^srcb[W-1], sign_r = srca[W-1]; clear iteration counter.
  - MUL: shift-add on magnitudes, one bit per cycle, 2*WIDTH accumulator.
  - DIV: restoring division on magnitudes, one quotient bit per cycle.
  - FIX: apply signs, write HI/LO, go to IDLE.
- Transitions:
  - IDLE -> MUL or DIV on an accepted start.
  - MUL/DIV -> FIX when counter == WIDTH-1.
  - FIX -> IDLE.
- Latency: start accepted at edge N; busy high for cycles N+1 .. N+WIDTH+1 (WIDTH+1 cycles). HI/LO are valid from edge N+WIDTH+1 and readable in the first cycle busy is low.
- Multiply:
  - {HI,LO} = signed 2W-bit product.
  - Negate the 2W-bit magnitude in FIX when sign_q=1.
- Divide:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Quotient is negated when sign_q=1; remainder is negated when sign_r=1.
  - Overflow case -2^(W-1) / -1: LO = 0x80000000, HI = 0; no flag.
- Divide by zero: detected in the accept cycle.
  - Still runs the full latency.
  - Result LO = all ones, HI = srca unchanged.
  - div_by_zero = 1 from FIX onward.
- Stall and reads:
  - rd_hi/rd_lo while busy asserts stall; result is don't-care while stall=1.
  - Once busy drops, the same-cycle read returns new HI/LO.
  - rd_hi and rd_lo together: HI wins.
- Start while busy: not accepted; stall held until IDLE, then accepted (stalled instruction is re-presented).
- Read and start in the same IDLE cycle: result returns the old HI/LO; the new operation is accepted.
- Reset mid-operation: abort; return to IDLE with HI=LO=0 on the next edge.
- Arithmetic: all internal adders are WIDTH+1 bits; no X propagation from unused accumulator bits.

Decomposition:
- Shared package (mips_pkg):
  - state encoding constants S_IDLE, S_MUL, S_DIV, S_FIX;
  - function-code constants for mult/div/mfhi/mflo;
  - WIDTH default.
- One natural sub-module: muldiv_core.
  - Contains the iterative datapath (accumulator, counter, add/subtract step).
  - Takes magnitudes, returns raw {hi,lo}.
  - FSM, sign handling, HI/LO registers and stall logic stay in muldiv_unit.

Test Plan:
1. mult srca=7, srcb=0xFFFFFFFD (-3) -> busy 33 cycles; then LO=0xFFFFFFEB, HI=0xFFFFFFFF.
2. div srca=100, srcb=7 -> LO=14, HI=2. Then div srca=0xFFFFFFF9 (-7), srcb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. div srca=5, srcb=0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1; next mult 2*3 clears the flag, LO=6, HI=0.
4. mult 0x10000*0x10000, then rd_lo held high -> stall=1 for all 33 busy cycles; first unstalled cycle result=0, and rd_hi gives 1.
5. div srca=0x80000000, srcb=0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0. Also start_mult and start_div together with 3,4 -> mult taken, LO=12.
6. reset at cycle 10 of a mult -> next edge busy=0, HI=LO=0; a following div 9/3 -> LO=3, HI=0.
